mode_cycle_selector: RTL and testbench

- Parametrised game-mode selector. Steps a mode index forward or backward through NUM_MODES values, one step per debounced button press.
- Presses are accepted only while the game FSM is in WAIT.
- Sits between the raw board buttons and the game core. Drives the mode consumed by the apple spawner and speed logic.
- Successor to the single-button 3-value luck selector. Adds synchronisation, debounce, press edge detection, prev/next buttons, wrap/saturate mode and a change strobe.

---
 rtl/mode_cycle_selector.sv | 104 ++++++++++
 tb/tb_mode_cycle_selector.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/mode_cycle_selector.sv
// Game-mode selector: synchronises and debounces prev/next buttons and steps a
// mode index (wrap or saturate) on each accepted press while the game is in WAIT.
module mode_cycle_selector #(
  parameter int NUM_MODES       = 3,
  parameter int MODE_W          = $clog2(NUM_MODES),
  parameter int DEFAULT_MODE    = 0,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int WRAP            = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_next,
  input  logic              btn_prev,
  input  logic [1:0]        state,
  output logic [MODE_W-1:0] mode,
  output logic              mode_changed,
  output logic              locked
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_WAIT     = 2'b01,
    ST_PAUSE    = 2'b10,
    ST_END_GAME = 2'b11
  } gameState_t;

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [MODE_W-1:0] MODE_MAX = MODE_W'(NUM_MODES - 1);
  localparam logic [MODE_W-1:0] MODE_DEF = MODE_W'(DEFAULT_MODE);

  // Index 0 is the "next" button, index 1 the "prev" button.
  logic [1:0]       w_raw;
  logic [1:0]       r_s1;
  logic [1:0]       r_s2;
  logic [1:0]       r_deb;
  logic [CNT_W-1:0] r_cnt [2];
  logic [1:0]       w_press;
  logic             w_accept;
  logic [MODE_W-1:0] w_modeNext;
  logic [MODE_W-1:0] r_mode;
  logic              r_changed;

  assign w_raw = {btn_prev, btn_next};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1  <= '0;
      r_s2  <= '0;
      r_deb <= '0;
      for (int i = 0; i < 2; i++) r_cnt[i] <= '0;
    end else begin
      r_s1 <= w_raw;
      r_s2 <= r_s1;
      for (int i = 0; i < 2; i++) begin
        if (r_s2[i] == r_deb[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_LAST) begin
          r_deb[i] <= r_s2[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // A press fires on the same edge that the debounced level rises.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      w_press[i] = r_s2[i] & ~r_deb[i] & (r_cnt[i] == CNT_LAST);
    end
  end

  assign w_accept = (gameState_t'(state) == ST_WAIT) && (w_press[0] != w_press[1]);

  always_comb begin
    w_modeNext = r_mode;
    if (w_accept) begin
      if (w_press[0]) begin
        if (r_mode == MODE_MAX) w_modeNext = (WRAP != 0) ? '0 : r_mode;
        else                    w_modeNext = r_mode + MODE_W'(1);
      end else begin
        if (r_mode == '0)       w_modeNext = (WRAP != 0) ? MODE_MAX : r_mode;
        else                    w_modeNext = r_mode - MODE_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode    <= MODE_DEF;
      r_changed <= 1'b0;
    end else begin
      r_mode    <= w_modeNext;
      r_changed <= (w_modeNext != r_mode);
    end
  end

  assign mode         = r_mode;
  assign mode_changed = r_changed;
  assign locked       = (gameState_t'(state) != ST_WAIT);

endmodule

// File: tb/tb_mode_cycle_selector.sv
// Directed bench driving three selector variants (3-mode wrap, 3-mode saturate,
// 5-mode wrap with default 3) from shared buttons, state and reset.
module tb_mode_cycle_selector;

  localparam logic [1:0] RUN  = 2'b00;
  localparam logic [1:0] WAIT = 2'b01;

  logic       clk = 1'b0;
  logic       rst;
  logic       btnNext;
  logic       btnPrev;
  logic [1:0] state;

  logic [1:0] modeW, modeS;
  logic [2:0] mode5;
  logic       chW, chS, ch5;
  logic       lockW, lockS, lock5;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mode_cycle_selector #(.NUM_MODES(3), .WRAP(1)) dutW (
    .clk(clk), .rst(rst), .btn_next(btnNext), .btn_prev(btnPrev), .state(state),
    .mode(modeW), .mode_changed(chW), .locked(lockW));

  mode_cycle_selector #(.NUM_MODES(3), .WRAP(0)) dutS (
    .clk(clk), .rst(rst), .btn_next(btnNext), .btn_prev(btnPrev), .state(state),
    .mode(modeS), .mode_changed(chS), .locked(lockS));

  mode_cycle_selector #(.NUM_MODES(5), .DEFAULT_MODE(3), .WRAP(1)) dut5 (
    .clk(clk), .rst(rst), .btn_next(btnNext), .btn_prev(btnPrev), .state(state),
    .mode(mode5), .mode_changed(ch5), .locked(lock5));

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  // Expected mode/strobe for each of the three variants.
  task automatic checkAll(input string tag, input int w, input int cw,
                          input int s, input int cs, input int f, input int cf);
    checkOutput({tag, " modeW"}, int'(modeW), w);
    checkOutput({tag, " chW"},   int'(chW),   cw);
    checkOutput({tag, " modeS"}, int'(modeS), s);
    checkOutput({tag, " chS"},   int'(chS),   cs);
    checkOutput({tag, " mode5"}, int'(mode5), f);
    checkOutput({tag, " ch5"},   int'(ch5),   cf);
  endtask

  // Drives the buttons now, then waits the given number of falling edges.
  task automatic applyStimulus(input logic n, input logic p, input int cycles);
    btnNext = n;
    btnPrev = p;
    repeat (cycles) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; btnNext = 1'b0; btnPrev = 1'b0; state = WAIT;
    #1;
    checkAll("reset", 0, 0, 0, 0, 3, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checkOutput("lockedWait", int'(lockW), 0);

    // Next held from before edge 1: update lands on edge 6.
    applyStimulus(1, 0, 5);
    checkAll("next1 early", 0, 0, 0, 0, 3, 0);
    applyStimulus(1, 0, 1);
    checkAll("next1", 1, 1, 1, 1, 4, 1);
    applyStimulus(1, 0, 1);
    checkAll("next1 hold", 1, 0, 1, 0, 4, 0);
    applyStimulus(1, 0, 5);
    checkAll("next1 hold long", 1, 0, 1, 0, 4, 0);
    applyStimulus(0, 0, 6);
    applyStimulus(1, 0, 6);
    checkAll("next2", 2, 1, 2, 1, 0, 1);
    applyStimulus(0, 0, 6);
    applyStimulus(1, 0, 6);
    checkAll("next3 wrap/sat", 0, 1, 2, 0, 1, 1);
    applyStimulus(0, 0, 6);
    applyStimulus(1, 0, 6);
    checkAll("next4", 1, 1, 2, 0, 2, 1);
    applyStimulus(0, 0, 6);

    // Prev presses, including wrap below zero and saturation at zero.
    applyStimulus(0, 1, 6);
    checkAll("prev1", 0, 1, 1, 1, 1, 1);
    applyStimulus(0, 0, 6);
    applyStimulus(0, 1, 6);
    checkAll("prev2 wrap", 2, 1, 0, 1, 0, 1);
    applyStimulus(0, 0, 6);
    applyStimulus(0, 1, 6);
    checkAll("prev3 sat", 1, 1, 0, 0, 4, 1);
    applyStimulus(0, 0, 6);

    // Three-cycle glitch is too short; bounce then steady high gives one step.
    applyStimulus(1, 0, 3);
    applyStimulus(0, 0, 8);
    checkAll("glitch", 1, 0, 0, 0, 4, 0);
    applyStimulus(1, 0, 1);
    applyStimulus(0, 0, 1);
    applyStimulus(1, 0, 5);
    checkAll("bounce early", 1, 0, 0, 0, 4, 0);
    applyStimulus(1, 0, 1);
    checkAll("bounce", 2, 1, 1, 1, 0, 1);
    applyStimulus(1, 0, 4);
    checkAll("bounce hold", 2, 0, 1, 0, 0, 0);
    applyStimulus(0, 0, 6);

    // Locked states discard presses; a button held into WAIT must not fire.
    state = RUN;
    #1;
    checkOutput("lockedRun W", int'(lockW), 1);
    checkOutput("lockedRun 5", int'(lock5), 1);
    applyStimulus(1, 0, 6);
    checkAll("run press", 2, 0, 1, 0, 0, 0);
    applyStimulus(1, 0, 4);
    state = WAIT;
    applyStimulus(1, 0, 8);
    checkAll("held into wait", 2, 0, 1, 0, 0, 0);
    checkOutput("unlocked", int'(lockS), 0);
    applyStimulus(0, 0, 6);
    checkAll("release", 2, 0, 1, 0, 0, 0);
    applyStimulus(1, 0, 6);
    checkAll("fresh press", 0, 1, 2, 1, 1, 1);
    applyStimulus(0, 0, 6);

    // Simultaneous presses cancel; staggered presses both apply.
    applyStimulus(1, 1, 6);
    checkAll("both", 0, 0, 2, 0, 1, 0);
    applyStimulus(1, 1, 2);
    checkAll("both hold", 0, 0, 2, 0, 1, 0);
    applyStimulus(0, 0, 6);
    applyStimulus(1, 0, 2);
    applyStimulus(1, 1, 4);
    checkAll("stagger next", 1, 1, 2, 0, 2, 1);
    applyStimulus(1, 1, 2);
    checkAll("stagger prev", 0, 1, 1, 1, 1, 1);
    applyStimulus(0, 0, 6);

    // Async reset clears the strobe immediately.
    applyStimulus(1, 0, 6);
    checkAll("pre-reset", 1, 1, 2, 1, 2, 1);
    rst = 1'b1;
    #1;
    checkAll("async reset", 0, 0, 0, 0, 3, 0);
    applyStimulus(1, 0, 2);
    rst = 1'b0;
    applyStimulus(1, 0, 5);
    checkAll("held thru reset early", 0, 0, 0, 0, 3, 0);
    applyStimulus(1, 0, 1);
    checkAll("held thru reset", 1, 1, 1, 1, 4, 1);
    applyStimulus(0, 0, 6);

    // Reset in the middle of a debounce window.
    applyStimulus(1, 0, 3);
    rst = 1'b1;
    #1;
    checkAll("mid-debounce reset", 0, 0, 0, 0, 3, 0);
    applyStimulus(0, 0, 2);
    rst = 1'b0;
    applyStimulus(0, 0, 8);
    checkAll("after reset idle", 0, 0, 0, 0, 3, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
